// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//   Behavioural model of a line-wide data memory that answers cache refill
//   and write-back requests after a fixed latency. One request is in flight
//   at a time; its inputs are captured when it is accepted.
//
//   Parameters
//     LATENCY  cycles from the accepting edge to the ack pulse (2..255)
//     LINE_W   line-index width; the array holds 2**LINE_W lines of 256 bits
//
//   Ports
//     clk_i     in   clock, rising edge
//     rst_i     in   synchronous active-high reset (control and data_o only)
//     enable_i  in   request valid
//     write_i   in   1 = line write, 0 = line read
//     addr_i    in   byte address, line index = addr_i[5+LINE_W-1:5]
//     data_i    in   write line data
//     ack_o     out  one-cycle completion pulse
//     data_o    out  read line data, held until the next read completes
//
//   Build option
//     DMEM_ABORT_EN  when defined, dropping enable_i while busy cancels the
//                    request silently (no ack, no write, data_o unchanged).
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int LATENCY = 10,
    parameter int LINE_W  = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         enable_i,
    input  logic         write_i,
    input  logic [31:0]  addr_i,
    input  logic [255:0] data_i,
    output logic         ack_o,
    output logic [255:0] data_o
);

    localparam logic [7:0] LAT_M1 = 8'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    state_t             state;
    state_t             state_nxt;
    logic [7:0]         cnt;
    logic               accept;
    logic               commit;

    logic               wr_q;
    logic [LINE_W-1:0]  line_q;
    logic [255:0]       wdata_q;

    logic [255:0]       mem [0:(2**LINE_W)-1];

    // Offset and upper address bits carry no meaning for a line memory.
    logic               unused_addr;
    assign unused_addr = ^{addr_i[31:5+LINE_W], addr_i[4:0]};

    // Next-state logic. 'commit' marks the edge entering ACK, where the
    // captured request takes effect on the array or on data_o.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (enable_i) begin
                    state_nxt = BUSY;
                    accept    = 1'b1;
                end
            end
            BUSY: begin
                if (cnt == 8'd1) begin
                    state_nxt = ACK;
                    commit    = 1'b1;
                end
`ifdef DMEM_ABORT_EN
                // Abort wins over completion on the same edge.
                if (!enable_i) begin
                    state_nxt = IDLE;
                    commit    = 1'b0;
                end
`endif
            end
            ACK: begin
                // enable_i is deliberately not looked at here; the held
                // request is picked up by IDLE on the following edge.
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Control state, latency counter and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            cnt    <= 8'd0;
            ack_o  <= 1'b0;
            data_o <= '0;
        end else begin
            state <= state_nxt;
            ack_o <= (state_nxt == ACK);
            if (accept) begin
                cnt <= LAT_M1;
            end else if (state == BUSY && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end
            if (commit && !wr_q) begin
                data_o <= mem[line_q];
            end
        end
    end

    // Request capture; later input changes are ignored until completion.
    always_ff @(posedge clk_i) begin
        if (accept) begin
            wr_q    <= write_i;
            line_q  <= addr_i[5+LINE_W-1:5];
            wdata_q <= data_i;
        end
    end

    // Array is never reset. A reset on the would-be commit edge discards
    // the pending write.
    always_ff @(posedge clk_i) begin
        if (commit && wr_q && !rst_i) begin
            mem[line_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//   Directed bench for dmem_responder. Instance 'dut' uses LATENCY=10 and
//   LINE_W=5; instance 'dut2' uses LATENCY=2 and LINE_W=5. Cycle numbering:
//   the accepting edge is edge 0 and cycle N is the period ending at edge N,
//   so an ack in cycle N is visible just after edge N-1.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    logic         clk = 1'b0;
    logic         rst;

    logic         en, wr;
    logic [31:0]  addr;
    logic [255:0] din;
    logic         ack;
    logic [255:0] dout;

    logic         en2, wr2;
    logic [31:0]  addr2;
    logic [255:0] din2;
    logic         ack2;
    logic [255:0] dout2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_responder #(.LATENCY(10), .LINE_W(5)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (en),
        .write_i  (wr),
        .addr_i   (addr),
        .data_i   (din),
        .ack_o    (ack),
        .data_o   (dout)
    );

    dmem_responder #(.LATENCY(2), .LINE_W(5)) dut2 (
        .clk_i    (clk),
        .rst_i    (rst),
        .enable_i (en2),
        .write_i  (wr2),
        .addr_i   (addr2),
        .data_i   (din2),
        .ack_o    (ack2),
        .data_o   (dout2)
    );

    localparam logic [255:0] A5 = {32{8'hA5}};
    localparam logic [255:0] D1 = {8{32'hDEADBEEF}};
    localparam logic [255:0] P2 = {16{16'h2222}};
    localparam logic [255:0] X2 = {16{16'h5A5A}};
    localparam logic [255:0] P4 = {16{16'h4444}};
    localparam logic [255:0] Q4 = {16{16'hC3C3}};
    localparam logic [255:0] R5 = {8{32'h0BADF00D}};
    localparam logic [255:0] S6 = {32{8'h66}};
    localparam logic [255:0] T9 = {32{8'h99}};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Edges until ack is seen on dut (bounded); -1 if it never comes.
    task automatic wait_ack(output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            step();
            if (ack) begin
                n = k;
                break;
            end
        end
    endtask

    // Issue one request on dut; returns the cycle number of the ack.
    // Without 'hold' the inputs are scrambled right after acceptance.
    task automatic do_req(input bit w, input logic [31:0] a, input logic [255:0] d,
                          input bit hold, output int cyc);
        int n;
        en = 1'b1; wr = w; addr = a; din = d;
        step();
        if (!hold) begin
            en = 1'b0; wr = ~w; addr = a ^ 32'h60; din = ~d;
        end
        wait_ack(n);
        cyc = (n < 0) ? -1 : n + 1;
    endtask

    task automatic finish_ack(input string tag);
        step();
        chk(tag, ack, 1'b0);
    endtask

    initial begin
        int cyc, gap, e;
        logic seen;
        logic [255:0] held;

        rst = 1'b1;
        en = 1'b0; wr = 1'b0; addr = '0; din = '0;
        en2 = 1'b0; wr2 = 1'b0; addr2 = '0; din2 = '0;
        dut.mem[3]  = A5;
        dut.mem[2]  = P2;
        dut.mem[4]  = P4;
        dut2.mem[6] = S6;
        dut2.mem[9] = T9;
        repeat (3) step();
        chk("rst_ack", ack, 1'b0);
        chk("rst_dout", dout, '0);
        chk("rst_ack2", ack2, 1'b0);
        chk("rst_dout2", dout2, '0);
        rst = 1'b0;

        // Read latency: line 3 via addr 0x60
        do_req(1'b0, 32'h60, '0, 1'b0, cyc);
        chk("rd_lat", cyc, 10);
        chk("rd_data", dout, A5);
        finish_ack("rd_pulse_one");

        // Write-back then refill with enable held high
        do_req(1'b1, 32'hE0, 256'h1234, 1'b1, cyc);
        chk("wb_lat", cyc, 10);
        chk("wb_dout_kept", dout, A5);
        wr = 1'b0; addr = 32'h4E0; din = '0;
        wait_ack(gap);
        chk("wb_refill_gap", gap, 11);
        chk("refill_data", dout, 256'h1234);
        en = 1'b0;
        finish_ack("refill_pulse_one");

        // Offset bits ignored: 0x21 and 0x3F both map to line 1
        do_req(1'b1, 32'h21, D1, 1'b0, cyc);
        chk("ofs_wr_lat", cyc, 10);
        finish_ack("ofs_wr_pulse");
        chk("ofs_mem1", dut.mem[1], D1);
        do_req(1'b0, 32'h3F, '0, 1'b0, cyc);
        chk("ofs_rd_lat", cyc, 10);
        chk("ofs_rd_data", dout, D1);
        finish_ack("ofs_rd_pulse");

        // Reset while busy: write to line 2 discarded
        en = 1'b1; wr = 1'b1; addr = 32'h40; din = X2;
        step();
        en = 1'b0; wr = 1'b0; addr = '0; din = '0;
        repeat (3) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        seen = 1'b0;
        repeat (15) begin
            step();
            if (ack) seen = 1'b1;
        end
        chk("rstmid_noack", seen, 1'b0);
        chk("rstmid_mem2", dut.mem[2], P2);
        do_req(1'b0, 32'h40, '0, 1'b0, cyc);
        chk("rstmid_rd_lat", cyc, 10);
        chk("rstmid_rd_data", dout, P2);
        finish_ack("rstmid_rd_pulse");

        // enable_i dropped before edge 3 of a write to line 4
        held = dout;
        en = 1'b1; wr = 1'b1; addr = 32'h80; din = Q4;
        step();
        repeat (2) step();
        en = 1'b0;
        cyc = -1;
        for (e = 3; e <= 25; e++) begin
            step();
            if (ack && cyc < 0) cyc = e + 1;
        end
`ifdef DMEM_ABORT_EN
        chk("abort_noack", cyc, -1);
        chk("abort_mem4", dut.mem[4], P4);
        chk("abort_dout", dout, held);
`else
        chk("noabort_lat", cyc, 10);
        chk("noabort_mem4", dut.mem[4], Q4);
        chk("noabort_dout", dout, held);
`endif

        // Reset in the ACK cycle: pulse cut, committed write kept
        do_req(1'b1, 32'hA0, R5, 1'b0, cyc);
        chk("rstack_lat", cyc, 10);
        rst = 1'b1;
        step();
        chk("rstack_ack", ack, 1'b0);
        chk("rstack_mem5", dut.mem[5], R5);
        chk("rstack_dout", dout, '0);
        rst = 1'b0;
        step();

        // LATENCY=2: read line 6, then held enable starts read of line 9
        en2 = 1'b1; wr2 = 1'b0; addr2 = 32'hC0; din2 = '0;
        step();
        chk("l2_c1_ack", ack2, 1'b0);
        addr2 = 32'h120;
        step();
        chk("l2_c2_ack", ack2, 1'b1);
        chk("l2_c2_data", dout2, S6);
        step();
        chk("l2_c3_ack", ack2, 1'b0);
        step();
        en2 = 1'b0;
        chk("l2_c4_ack", ack2, 1'b0);
        step();
        chk("l2_c5_ack", ack2, 1'b1);
        chk("l2_c5_data", dout2, T9);
        step();
        chk("l2_c6_ack", ack2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The module SHALL have parameter LATENCY, default 10, giving cycles from request acceptance to ack (legal range 2..255).
REQ-002 The module SHALL have parameter LINE_W, default 9, giving the line-index width; depth is 2**LINE_W lines of 256 bits.
REQ-003 The module SHALL have port clk_i  input  1  single clock; all logic on the rising edge.
REQ-004 The module SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 The module SHALL have port enable_i  input  1  request valid from the cache controller.
REQ-006 The module SHALL have port write_i  input  1  1 = line write, 0 = line read.
REQ-007 The module SHALL have port addr_i  input  32  byte address; line index = addr_i[5+LINE_W-1:5]; bits [4:0] and the upper bits are ignored.
REQ-008 The module SHALL have port data_i  input  256  write line data.
REQ-009 The module SHALL have port ack_o  output  1  one-cycle completion pulse.
REQ-010 The module SHALL have port data_o  output  256  read line data.

Function
REQ-011 The FSM SHALL have three states: IDLE, BUSY and ACK.
REQ-012 In IDLE, when enable_i=1 at a rising edge, the module SHALL accept the request: capture write_i, the line index and data_i; load the counter with LATENCY-1; and go to BUSY.
REQ-013 Input changes after acceptance SHALL be ignored until the request completes.
REQ-014 In BUSY, the counter SHALL decrement each cycle; at the edge where it equals 1, the module SHALL go to ACK.
REQ-015 ack_o SHALL be registered and high only in ACK, so the pulse occurs exactly LATENCY cycles after the acceptance edge and lasts exactly one cycle.
REQ-016 For a read, data_o SHALL be loaded from the captured line at the edge entering ACK and held until the next read completes.
REQ-017 For a write, the line SHALL be updated with the captured data at the edge entering ACK, and data_o SHALL remain unchanged.
REQ-018 ACK SHALL always return to IDLE on the next edge.
REQ-019 IDLE SHALL sample enable_i in the cycle immediately after ACK, so a held-high enable_i with new write_i/addr_i (write-back followed by refill) is accepted back-to-back.
REQ-020 enable_i=1 observed during ACK SHALL NOT itself start a request.
REQ-021 A read of a line written earlier SHALL return the new data; write-then-read of the same line with no gap SHALL return the written data.

Reset
REQ-022 When rst_i=1 at a rising edge, the module SHALL set state=IDLE, counter=0, ack_o=0 and data_o=0.
REQ-023 Memory array contents SHALL NOT be reset; benches preload the array hierarchically.
REQ-024 Reset during BUSY SHALL discard the pending request: no ack is issued and the pending write does not occur.
REQ-025 Reset asserted in the ACK cycle SHALL force ack_o=0 from the next cycle; a write committed on entry to ACK is retained.
REQ-026 The first request SHALL be accepted at the first edge with rst_i=0 and enable_i=1.

Configuration
REQ-027 With macro DMEM_ABORT_EN defined, enable_i=0 sampled at any edge while in BUSY SHALL return the FSM to IDLE without ack_o, without a memory write and without a data_o change.
REQ-028 With DMEM_ABORT_EN undefined, enable_i SHALL be ignored in BUSY and every accepted request SHALL complete with an ack.

Verification
REQ-029 The bench SHALL cover read latency: LATENCY=10, preload line 3=0xA5..A5, read addr 0x60 accepted at edge 0 -> ack_o high only in cycle 10, data_o=0xA5..A5.
REQ-030 The bench SHALL cover back-to-back write-back then refill: enable_i held high, write line 7 (addr 0xE0) data=0x1234, then read addr 0x4E0 (aliases line 7 with LINE_W=5) -> two acks 11 cycles apart, read returns 0x1234.
REQ-031 The bench SHALL cover offset ignore: write addr 0x21 and read addr 0x3F -> same line (index 1), read returns the written data.
REQ-032 The bench SHALL cover reset mid-request: write line 2 accepted, rst_i pulsed at cycle 4 -> no ack, line 2 unchanged, next read after reset acks at LATENCY.
REQ-033 The bench SHALL cover abort: with DMEM_ABORT_EN, drop enable_i at cycle 3 of a write -> no ack, line unchanged; without DMEM_ABORT_EN -> ack at cycle 10, line written.
REQ-034 The bench SHALL cover minimum latency: LATENCY=2 read -> ack_o high in cycle 2 only, next request accepted in cycle 3.
